// File: rtl/time_digit_converter.sv
// Converts the timer's remaining-seconds count into MM:SS BCD digits by repeated subtraction,
// and produces a blink strobe for the display while the timer reports the finished state.
module time_digit_converter #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] time_in,
   input  logic [1:0]  state_in,
   output logic [3:0]  min_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  sec_ones,
   output logic        digits_valid,
   output logic        overflow,
   output logic        busy,
   output logic        blank
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MIN_LOOP,
      S_SEC_LOOP,
      S_MT_LOOP,
      S_COMMIT
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   work_q, work_d;
   logic [15:0]   last_time_q, last_time_d;
   logic [6:0]    mins_q, mins_d;
   logic [3:0]    st_q, st_d;
   logic [3:0]    mt_q, mt_d;
   logic          sat_q, sat_d;
   logic          force_conv_q, force_conv_d;
   logic [3:0]    min_tens_q, min_tens_d;
   logic [3:0]    min_ones_q, min_ones_d;
   logic [3:0]    sec_tens_q, sec_tens_d;
   logic [3:0]    sec_ones_q, sec_ones_d;
   logic          digits_valid_q, digits_valid_d;
   logic          overflow_q, overflow_d;
   logic [CW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blank_q, blank_d;

   // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
   always_comb begin
      state_d        = state_q;
      work_d         = work_q;
      last_time_d    = last_time_q;
      mins_d         = mins_q;
      st_d           = st_q;
      mt_d           = mt_q;
      sat_d          = sat_q;
      force_conv_d   = force_conv_q;
      min_tens_d     = min_tens_q;
      min_ones_d     = min_ones_q;
      sec_tens_d     = sec_tens_q;
      sec_ones_d     = sec_ones_q;
      digits_valid_d = digits_valid_q;
      overflow_d     = overflow_q;

      case (state_q)
         S_IDLE: begin
            if (time_in != last_time_q || force_conv_q) begin
               last_time_d  = time_in;
               work_d       = time_in;
               mins_d       = 7'd0;
               st_d         = 4'd0;
               mt_d         = 4'd0;
               sat_d        = 1'b0;
               force_conv_d = 1'b0;
               state_d      = S_MIN_LOOP;
            end
         end
         S_MIN_LOOP: begin
            if (work_q >= 16'd60 && mins_q < 7'd99) begin
               work_d = work_q - 16'd60;
               mins_d = mins_q + 7'd1;
            end else begin
               sat_d   = (work_q >= 16'd60);
               state_d = S_SEC_LOOP;
            end
         end
         S_SEC_LOOP: begin
            if (sat_q) begin
               // Saturated seconds are 59, loaded already split into tens and ones.
               st_d    = 4'd5;
               work_d  = 16'd9;
               state_d = S_MT_LOOP;
            end else if (work_q >= 16'd10) begin
               work_d = work_q - 16'd10;
               st_d   = st_q + 4'd1;
            end else begin
               state_d = S_MT_LOOP;
            end
         end
         S_MT_LOOP: begin
            if (mins_q >= 7'd10) begin
               mins_d = mins_q - 7'd10;
               mt_d   = mt_q + 4'd1;
            end else begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            min_tens_d     = mt_q;
            min_ones_d     = mins_q[3:0];
            sec_tens_d     = st_q;
            sec_ones_d     = work_q[3:0];
            overflow_d     = sat_q;
            digits_valid_d = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
      if (state_in == 2'b11) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
            blank_d     = blank_q;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         work_q         <= '0;
         last_time_q    <= '0;
         mins_q         <= '0;
         st_q           <= '0;
         mt_q           <= '0;
         sat_q          <= 1'b0;
         force_conv_q   <= 1'b1;
         min_tens_q     <= '0;
         min_ones_q     <= '0;
         sec_tens_q     <= '0;
         sec_ones_q     <= '0;
         digits_valid_q <= 1'b0;
         overflow_q     <= 1'b0;
         blink_cnt_q    <= '0;
         blank_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         work_q         <= work_d;
         last_time_q    <= last_time_d;
         mins_q         <= mins_d;
         st_q           <= st_d;
         mt_q           <= mt_d;
         sat_q          <= sat_d;
         force_conv_q   <= force_conv_d;
         min_tens_q     <= min_tens_d;
         min_ones_q     <= min_ones_d;
         sec_tens_q     <= sec_tens_d;
         sec_ones_q     <= sec_ones_d;
         digits_valid_q <= digits_valid_d;
         overflow_q     <= overflow_d;
         blink_cnt_q    <= blink_cnt_d;
         blank_q        <= blank_d;
      end
   end

   assign min_tens     = min_tens_q;
   assign min_ones     = min_ones_q;
   assign sec_tens     = sec_tens_q;
   assign sec_ones     = sec_ones_q;
   assign digits_valid = digits_valid_q;
   assign overflow     = overflow_q;
   assign busy         = (state_q != S_IDLE);
   assign blank        = blank_q;

endmodule

// File: tb/tb_time_digit_converter.sv
// Scoreboard bench for time_digit_converter: stimulus pushes expected digits and latency,
// a monitor pops and compares each time a conversion commits (busy falling).
module tb_time_digit_converter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] time_in = 16'd0;
   logic [1:0]  state_in = 2'b00;
   logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
   logic        digits_valid, overflow, busy, blank;

   time_digit_converter #(.BLINK_DIV(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .time_in      (time_in),
      .state_in     (state_in),
      .min_tens     (min_tens),
      .min_ones     (min_ones),
      .sec_tens     (sec_tens),
      .sec_ones     (sec_ones),
      .digits_valid (digits_valid),
      .overflow     (overflow),
      .busy         (busy),
      .blank        (blank)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mt;
      logic [3:0] mo;
      logic [3:0] st;
      logic [3:0] so;
      logic       ovf;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] mt, input logic [3:0] mo, input logic [3:0] st,
                       input logic [3:0] so, input logic ovf, input int lat);
      exp_t e;
      e.mt = mt; e.mo = mo; e.st = st; e.so = so; e.ovf = ovf; e.lat = lat;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string name, input int max_cycles);
      bit done = 1'b0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL %s: timeout after %0d cycles, %0d results still pending", name, max_cycles, sb.size());
      end
   endtask

   // Monitor: a commit is the edge where busy drops; latency runs from the capture edge.
   initial begin
      logic prev_busy;
      int   start;
      exp_t e;
      prev_busy = 1'b0;
      start = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_busy = 1'b0;
         end else begin
            if (!prev_busy && busy) start = cyc;
            if (prev_busy && !busy) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_commit: got %0d%0d:%0d%0d expected no commit",
                           min_tens, min_ones, sec_tens, sec_ones);
               end else begin
                  e = sb.pop_front();
                  check("min_tens", 32'(min_tens), 32'(e.mt));
                  check("min_ones", 32'(min_ones), 32'(e.mo));
                  check("sec_tens", 32'(sec_tens), 32'(e.st));
                  check("sec_ones", 32'(sec_ones), 32'(e.so));
                  check("overflow", 32'(overflow), 32'(e.ovf));
                  check("digits_valid", 32'(digits_valid), 32'd1);
                  check("latency", 32'(cyc - start), 32'(e.lat));
               end
            end
            prev_busy = busy;
         end
      end
   end

   initial begin
      logic [11:0] blink_exp;
      blink_exp = 12'b1000_0111_1000;

      // Reset values, then the forced conversion of time_in = 0.
      repeat (3) @(negedge clk);
      check("rst_digits", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'd0);
      check("rst_valid", 32'(digits_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_blank", 32'(blank), 32'd0);
      push(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4);
      rst = 1'b0;
      @(negedge clk);
      check("busy_after_release", 32'(busy), 32'd1);
      wait_done("forced_conv", 20);

      time_in = 16'd125;
      push(4'd0, 4'd2, 4'd0, 4'd5, 1'b0, 6);
      wait_done("t125", 30);

      time_in = 16'd5999;
      push(4'd9, 4'd9, 4'd5, 4'd9, 1'b0, 117);
      wait_done("t5999", 200);
      time_in = 16'd6000;
      push(4'd9, 4'd9, 4'd5, 4'd9, 1'b1, 112);
      wait_done("t6000", 200);
      time_in = 16'd65535;
      push(4'd9, 4'd9, 4'd5, 4'd9, 1'b1, 112);
      wait_done("t65535", 200);

      // Change while busy: old value commits, then the new one without further stimulus.
      time_in = 16'd600;
      push(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 15);
      push(4'd0, 4'd0, 4'd5, 4'd9, 1'b0, 9);
      repeat (3) @(negedge clk);
      check("busy_mid_600", 32'(busy), 32'd1);
      time_in = 16'd59;
      wait_done("t600_then_59", 60);

      // Decrementing timer, one step per 8 cycles.
      time_in = 16'd61;
      push(4'd0, 4'd1, 4'd0, 4'd1, 1'b0, 5);
      repeat (8) @(negedge clk);
      time_in = 16'd60;
      push(4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 5);
      repeat (8) @(negedge clk);
      time_in = 16'd59;
      push(4'd0, 4'd0, 4'd5, 4'd9, 1'b0, 9);
      wait_done("countdown", 40);

      // Blink with BLINK_DIV = 4.
      state_in = 2'b11;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check($sformatf("blank_%0d", k + 1), 32'(blank), 32'(blink_exp[k]));
      end
      state_in = 2'b01;
      @(negedge clk);
      check("blank_cleared", 32'(blank), 32'd0);

      // Reset in the middle of a conversion while blank is high.
      time_in = 16'd100;
      state_in = 2'b11;
      repeat (5) @(negedge clk);
      check("busy_before_rst", 32'(busy), 32'd1);
      check("blank_before_rst", 32'(blank), 32'd1);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrst_digits", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'd0);
      check("midrst_valid", 32'(digits_valid), 32'd0);
      check("midrst_overflow", 32'(overflow), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_blank", 32'(blank), 32'd0);
      state_in = 2'b00;
      push(4'd0, 4'd1, 4'd4, 4'd0, 1'b0, 9);
      rst = 1'b0;
      wait_done("t100_after_rst", 30);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
